// File: rtl/yutorina_if_stage_if.sv
// Instruction-bus bundle between the fetch stage (master) and the instruction memory (slave).
// Read requests hold address until ack; data is valid in the ack cycle.
interface yutorina_if_stage_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic              bus_req;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;

   modport master (output bus_req, bus_addr, input bus_ack, bus_rdata);
   modport slave  (input bus_req, bus_addr, output bus_ack, bus_rdata);
endinterface

// File: rtl/yutorina_if_stage.sv
// Yutorina instruction-fetch stage: fetch PC, instruction-bus requests and the IF/ID register.
// Buffers one completion that lands during a stall and discards reads orphaned by a flush.
module yutorina_if_stage #(
   parameter int                 ADDR_W   = 30,
   parameter int                 DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter logic [DATA_W-1:0]  NOP_INSN = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [ADDR_W-1:0]     new_pc,
   yutorina_if_stage_if.master   bus,
   output logic                  i_busy,
   output logic [ADDR_W-1:0]     if_pc,
   output logic [DATA_W-1:0]     if_insn,
   output logic                  if_en_
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] redirect;
   logic [DATA_W-1:0] buf_insn;
   logic [ADDR_W-1:0] buf_pc;

   always_comb begin
      bus.bus_req  = (state == FETCH) || (state == DRAIN);
      bus.bus_addr = pc;
      i_busy       = ((state == FETCH) && !bus.bus_ack) || (state == DRAIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         redirect <= '0;
         buf_insn <= '0;
         buf_pc   <= '0;
         if_pc    <= '0;
         if_insn  <= NOP_INSN;
         if_en_   <= 1'b1;
      end else begin
         case (state)
            FETCH: begin
               if (flush) begin
                  if_en_  <= 1'b1;
                  if_insn <= NOP_INSN;
                  if (bus.bus_ack) begin
                     pc <= new_pc;
                  end else begin
                     redirect <= new_pc;
                     state    <= DRAIN;
                  end
               end else if (bus.bus_ack) begin
                  pc <= pc + ADDR_W'(1);
                  if (stall) begin
                     buf_insn <= bus.bus_rdata;
                     buf_pc   <= pc;
                     state    <= HOLD;
                  end else begin
                     if_insn <= bus.bus_rdata;
                     if_pc   <= pc;
                     if_en_  <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               // The outstanding read belongs to the old stream; only its ack matters.
               if_en_  <= 1'b1;
               if_insn <= NOP_INSN;
               if (flush) redirect <= new_pc;
               if (bus.bus_ack) begin
                  pc    <= flush ? new_pc : redirect;
                  state <= FETCH;
               end
            end
            HOLD: begin
               if (flush) begin
                  if_en_  <= 1'b1;
                  if_insn <= NOP_INSN;
                  pc      <= new_pc;
                  state   <= FETCH;
               end else if (!stall) begin
                  if_insn <= buf_insn;
                  if_pc   <= buf_pc;
                  if_en_  <= 1'b0;
                  state   <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule
